axis_accumulator_mc: RTL and testbench
======================================

Name: axis_accumulator_mc

Overview:
Multi-channel successor of the single-stream AXI4-Stream accumulator. Accepts a channel-interleaved sample stream (ch0, ch1, …, chN-1, ch0, …) and sums cfg_data frames per channel. It then emits one N-word result burst with m_axis_tlast on the last channel. A double-buffered output bank lets accumulation of the next block overlap the drain of the previous one. Used for averaging multi-channel ADC/spectrum data before DMA.

Parameters:
S_AXIS_TDATA_WIDTH, 16, input sample width
M_AXIS_TDATA_WIDTH, 32, accumulator/output width; must be >= S_AXIS_TDATA_WIDTH
CNTR_WIDTH, 16, frame counter width
CHANNELS, 4, interleaved channel count, >= 1
AXIS_TDATA_SIGNED, "FALSE", "TRUE" = sign-extend samples, else zero-extend
CONTINUOUS, "FALSE", "TRUE" = free-running blocks; "FALSE" = one block then stop

Ports:
aclk  input  1  clock
areset  input  1  synchronous reset, active-high
cfg_data  input  CNTR_WIDTH  frames per block; 0 treated as 1
sts_data  output  32  completed-block count, wraps
s_axis_tready  output  1  input ready
s_axis_tdata  input  S_AXIS_TDATA_WIDTH  sample
s_axis_tvalid  input  1  sample valid
m_axis_tready  input  1  output ready
m_axis_tdata  output  M_AXIS_TDATA_WIDTH  channel sum
m_axis_tvalid  output  1  result valid
m_axis_tlast  output  1  last channel of burst

Behaviour:
- Single clock domain: aclk. Reset is synchronous and active-high on areset.
- Reset values: all outputs 0; accumulators, counters, bank and run flag cleared. Reset mid-block discards partial sums and any undrained burst.
- Run flag: set the first cycle after reset deasserts. s_axis_tready = run & ~stall, where stall = (sample position is last of block) & bank_busy.
- Accept occurs when s_axis_tvalid & s_axis_tready. chan_idx advances 0..CHANNELS-1 and wraps. frame_cntr increments when chan_idx wraps.
- cfg_data is latched at the first accept of each block (frame 0, ch0). Changes mid-block have no effect until the next block.
- Per accept: acc[ch] <= (frame_cntr==0) ? ext(sample) : acc[ch] + ext(sample). No clear cycle is needed between blocks.
- Arithmetic: ext is sign- or zero-extension to M_AXIS_TDATA_WIDTH. Sums wrap modulo 2^M unless the optional feature is enabled.
- Block completion is the accept at frame_cntr==cfg-1, chan_idx==CHANNELS-1. On completion:
  - bank[i] <= acc[i] for i < CHANNELS-1; bank[CHANNELS-1] <= acc[CHANNELS-1] + ext(sample).
  - bank_busy <= 1; out_idx <= 0; sts_data increments; frame_cntr and chan_idx return to 0.
- Drain: m_axis_tvalid = bank_busy; m_axis_tdata = bank[out_idx]; m_axis_tlast = bank_busy & (out_idx==CHANNELS-1).
  - On tready & tvalid, out_idx advances. After the last word, bank_busy clears.
  - First word is valid 1 cycle after the completing accept. tdata/tlast stay stable while tvalid & ~tready.
- Simultaneous events: the final drain beat and a new completing accept in the same cycle is not possible, because stall blocks that accept. The cycle after the drain ends, tready reasserts. Accepts at non-final positions proceed during a drain.
- CONTINUOUS="FALSE": after the first completion, run clears and s_axis_tready stays 0 until reset. The pending burst still drains normally.
- CHANNELS==1 degenerates to a single-stream accumulator with tlast on every word.

Optional Feature:
- Macro: AXIS_ACCUMULATOR_MC_SAT_EN.
- Defined:
  - Each add saturates to the M-width max/min (unsigned: 2^M-1; signed: ±full scale) instead of wrapping.
  - An extra output port sts_overflow (1 bit, reset 0) is added. It sets sticky whenever any channel saturates in a block and clears only on reset.
- Undefined: modular wrap, and the sts_overflow port is absent.

Decomposition:
- Package axis_accumulator_mc_pkg: signedness/mode string constants and helper functions ext_sample() and sat_add().
- Sub-module axis_accumulator_mc_bank: output double-buffer plus drain sequencer (bank regs, out_idx, tvalid/tlast). The top keeps counters, accumulators and input handshake.

Test Plan:
- CHANNELS=4, cfg=2, unsigned, inputs 1,2,3,4,10,20,30,40 with tready=1 -> burst 11,22,33,44; tlast on 44; sts_data=1.
- Signed, CHANNELS=2, cfg=3, inputs -1,5 ×3 -> outputs 0xFFFFFFFD, 15.
- CONTINUOUS="TRUE", m_axis_tready=0 held while a second block's last sample is offered -> s_axis_tready=0 at that sample only. Release tready -> first burst drains unchanged, then the second block completes.
- CONTINUOUS="FALSE", cfg=1 -> one burst, then s_axis_tready stays 0 for 100 cycles; areset pulse -> tready returns 1 cycle after deassert.
- Change cfg from 2 to 5 mid-block -> current block uses 2 frames, next uses 5. cfg=0 -> 1 frame per block.
- With AXIS_ACCUMULATOR_MC_SAT_EN, M=16, S=16, unsigned, 0xFFFF+0x0002 -> output 0xFFFF and sts_overflow=1. Without the macro -> output 0x0001.

Source files
------------

// File: rtl/axis_accumulator_mc_pkg.sv
// Shared constants and arithmetic helpers for the multi-channel AXI4-Stream accumulator.
// Helpers work on a 64-bit scratch word. Callers pass the real widths and truncate the result.
// Supported widths: M_AXIS_TDATA_WIDTH must be below 64.
package axis_accumulator_mc_pkg;

  localparam string       StrTrue  = "TRUE";
  localparam int unsigned MaxWidth = 64;

  typedef logic [MaxWidth-1:0] word_t;

  // Extend the low w bits of s: sign-extend when sgn is set, otherwise zero-extend.
  function automatic word_t ext_sample(input word_t s, input int unsigned w, input bit sgn);
    word_t r;
    logic  fill;
    fill = sgn & s[6'(w - 1)];
    for (int unsigned i = 0; i < MaxWidth; i++) begin
      r[i] = (i < w) ? s[i] : fill;
    end
    return r;
  endfunction

  // Overflow of a w-bit add. The inputs must already be extended with ext_sample().
  function automatic logic add_overflow(input word_t a, input word_t b, input int unsigned w,
                                        input bit sgn);
    word_t sum;
    sum = a + b;
    if (sgn) begin
      return (a[6'(w - 1)] == b[6'(w - 1)]) && (sum[6'(w - 1)] != a[6'(w - 1)]);
    end
    return sum[6'(w)];
  endfunction

  // w-bit add. With sat_en set, clamp to the representable range instead of wrapping.
  function automatic word_t sat_add(input word_t a, input word_t b, input int unsigned w,
                                    input bit sgn, input bit sat_en);
    word_t sum;
    word_t lim;
    sum = a + b;
    // Signed overflow only happens with equal operand signs; a's sign picks min or max.
    for (int unsigned i = 0; i < MaxWidth; i++) begin
      if (i >= w)          lim[i] = 1'b0;
      else if (!sgn)       lim[i] = 1'b1;
      else if (i == w - 1) lim[i] = a[6'(w - 1)];
      else                 lim[i] = ~a[6'(w - 1)];
    end
    return (sat_en && add_overflow(a, b, w, sgn)) ? lim : sum;
  endfunction

endpackage

// File: rtl/axis_accumulator_mc_bank.sv
// Output holding bank and drain sequencer for axis_accumulator_mc.
// A completed block is loaded in one cycle. The bank then drains one channel per m_axis beat,
// and asserts tlast on the last channel.
// Ports: clk/rst (sync, active-high), load/load_data (completed sums), busy (bank holds an
//        undrained burst), m_axis_tready/tdata/tvalid/tlast (result stream).
module axis_accumulator_mc_bank
  import axis_accumulator_mc_pkg::*;
#(
  parameter int unsigned CHANNELS   = 4,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 load,
  input  logic [CHANNELS-1:0][DATA_WIDTH-1:0]  load_data,
  output logic                                 busy,
  input  logic                                 m_axis_tready,
  output logic [DATA_WIDTH-1:0]                m_axis_tdata,
  output logic                                 m_axis_tvalid,
  output logic                                 m_axis_tlast
);

  localparam int unsigned IdxW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(CHANNELS - 1);

  logic [CHANNELS-1:0][DATA_WIDTH-1:0] bank_q;
  logic [IdxW-1:0]                     idx_q;
  logic                                busy_q;

  // The upstream stall guarantees load never coincides with a busy bank.
  always_ff @(posedge clk) begin
    if (rst) begin
      bank_q <= '0;
      idx_q  <= '0;
      busy_q <= 1'b0;
    end else if (load) begin
      bank_q <= load_data;
      idx_q  <= '0;
      busy_q <= 1'b1;
    end else if (busy_q && m_axis_tready) begin
      if (idx_q == LastIdx) begin
        idx_q  <= '0;
        busy_q <= 1'b0;
      end else begin
        idx_q <= idx_q + 1'b1;
      end
    end
  end

  always_comb begin
    busy          = busy_q;
    m_axis_tvalid = busy_q;
    m_axis_tdata  = bank_q[idx_q];
    m_axis_tlast  = busy_q && (idx_q == LastIdx);
  end

endmodule

// File: rtl/axis_accumulator_mc.sv
// Multi-channel AXI4-Stream block accumulator.
// Input samples arrive channel-interleaved. Each channel is summed over cfg_data frames
// (0 counts as 1), and the result goes out as one CHANNELS-word burst with tlast on the last
// channel. A holding bank lets the next block accumulate while the previous burst drains.
// Optional: define AXIS_ACCUMULATOR_MC_SAT_EN for saturating adds and a sticky sts_overflow port.
// Ports: aclk, areset (sync, active-high), cfg_data (frames per block), sts_data (completed
//        blocks), s_axis_* (sample input), m_axis_* (result output), sts_overflow (optional).
// Constraints: M_AXIS_TDATA_WIDTH must be >= S_AXIS_TDATA_WIDTH and < 64.
module axis_accumulator_mc
  import axis_accumulator_mc_pkg::*;
#(
  parameter int unsigned S_AXIS_TDATA_WIDTH = 16,
  parameter int unsigned M_AXIS_TDATA_WIDTH = 32,
  parameter int unsigned CNTR_WIDTH         = 16,
  parameter int unsigned CHANNELS           = 4,
  parameter string       AXIS_TDATA_SIGNED  = "FALSE",
  parameter string       CONTINUOUS         = "FALSE"
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic [CNTR_WIDTH-1:0]         cfg_data,
  output logic [31:0]                   sts_data,
  output logic                          s_axis_tready,
  input  logic [S_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                          s_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic [M_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                          m_axis_tvalid,
  output logic                          m_axis_tlast
`ifdef AXIS_ACCUMULATOR_MC_SAT_EN
  ,
  output logic                          sts_overflow
`endif
);

  localparam bit Signed     = (AXIS_TDATA_SIGNED == StrTrue);
  localparam bit Continuous = (CONTINUOUS == StrTrue);
`ifdef AXIS_ACCUMULATOR_MC_SAT_EN
  localparam bit SatEn = 1'b1;
`else
  localparam bit SatEn = 1'b0;
`endif
  localparam int unsigned ChW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [ChW-1:0] LastCh = ChW'(CHANNELS - 1);

  logic                                        run_q, done_q;
  logic [ChW-1:0]                              chan_q;
  logic [CNTR_WIDTH-1:0]                       frame_q, cfg_q, cfg_eff;
  logic [M_AXIS_TDATA_WIDTH-1:0]               acc_q [CHANNELS];
  logic [31:0]                                 sts_q;
  logic                                        first_pos, last_pos, bank_busy, accept, complete;
  word_t                                       acc_w, samp_w;
  logic [M_AXIS_TDATA_WIDTH-1:0]               samp_ext, acc_sum, new_val;
  logic [CHANNELS-1:0][M_AXIS_TDATA_WIDTH-1:0] load_data;

  always_comb begin
    first_pos = (frame_q == '0) && (chan_q == '0);
    // The block length comes from cfg_data at the first sample and from cfg_q after that.
    // This lets a 1-frame block complete on its very first accept.
    cfg_eff   = first_pos ? ((cfg_data == '0) ? CNTR_WIDTH'(1) : cfg_data) : cfg_q;
    last_pos  = (frame_q == cfg_eff - CNTR_WIDTH'(1)) && (chan_q == LastCh);
    s_axis_tready = run_q & ~(last_pos & bank_busy);
    accept    = s_axis_tvalid & s_axis_tready;
    complete  = accept & last_pos;

    acc_w    = ext_sample(word_t'(acc_q[chan_q]), M_AXIS_TDATA_WIDTH, Signed);
    samp_w   = ext_sample(word_t'(s_axis_tdata), S_AXIS_TDATA_WIDTH, Signed);
    samp_ext = M_AXIS_TDATA_WIDTH'(samp_w);
    acc_sum  = M_AXIS_TDATA_WIDTH'(sat_add(acc_w, samp_w, M_AXIS_TDATA_WIDTH, Signed, SatEn));
    // Frame 0 overwrites the channel sum, so no clear cycle is needed between blocks.
    new_val  = (frame_q == '0) ? samp_ext : acc_sum;

    for (int unsigned i = 0; i < CHANNELS; i++) begin
      load_data[i] = acc_q[i];
    end
    // The last channel's sum is still in flight on the completing accept.
    load_data[CHANNELS-1] = new_val;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      run_q   <= 1'b0;
      done_q  <= 1'b0;
      chan_q  <= '0;
      frame_q <= '0;
      cfg_q   <= '0;
      sts_q   <= '0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        acc_q[i] <= '0;
      end
    end else begin
      if (complete && !Continuous) begin
        run_q  <= 1'b0;
        done_q <= 1'b1;
      end else if (!done_q) begin
        run_q <= 1'b1;
      end
      if (accept) begin
        acc_q[chan_q] <= new_val;
        if (first_pos) cfg_q <= cfg_eff;
        if (complete) begin
          chan_q  <= '0;
          frame_q <= '0;
          sts_q   <= sts_q + 32'd1;
        end else if (chan_q == LastCh) begin
          chan_q  <= '0;
          frame_q <= frame_q + 1'b1;
        end else begin
          chan_q <= chan_q + 1'b1;
        end
      end
    end
  end

  assign sts_data = sts_q;

`ifdef AXIS_ACCUMULATOR_MC_SAT_EN
  logic ovf_q, add_ovf;

  always_comb begin
    add_ovf = add_overflow(acc_w, samp_w, M_AXIS_TDATA_WIDTH, Signed);
  end

  // Frame 0 loads without adding, so only later frames can saturate.
  always_ff @(posedge aclk) begin
    if (areset) begin
      ovf_q <= 1'b0;
    end else if (accept && (frame_q != '0) && add_ovf) begin
      ovf_q <= 1'b1;
    end
  end

  assign sts_overflow = ovf_q;
`endif

  axis_accumulator_mc_bank #(
    .CHANNELS   (CHANNELS),
    .DATA_WIDTH (M_AXIS_TDATA_WIDTH)
  ) u_bank (
    .clk           (aclk),
    .rst           (areset),
    .load          (complete),
    .load_data     (load_data),
    .busy          (bank_busy),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast)
  );

endmodule

// File: tb/tb_axis_accumulator_mc.sv
// Directed bench for axis_accumulator_mc. Three instances share the stimulus, and only the
// selected one is out of reset:
//   u_a: 4 channels, unsigned, continuous (basic burst, stall, cfg change, cfg=0)
//   u_b: 2 channels, signed, single-shot (signed sums, stop after one block, reset restart)
//   u_c: 1 channel, 16-bit unsigned (wrap or saturation, tlast on every word)
module tb_axis_accumulator_mc;

  logic        clk = 1'b0;
  logic [2:0]  rst = 3'b111;
  logic [15:0] cfg = 16'd2;
  logic [15:0] s_tdata = '0;
  logic        s_tvalid = 1'b0;
  logic        m_tready = 1'b0;
  int          sel = 0;
  int          n_cmp = 0;
  int          n_err = 0;

  logic [31:0] a_sts, b_sts, c_sts, a_data, b_data;
  logic [15:0] c_data;
  logic        a_srdy, b_srdy, c_srdy, a_vld, b_vld, c_vld, a_last, b_last, c_last;
  logic        a_ovf, b_ovf, c_ovf;

  logic        s_rdy, m_vld, m_last;
  logic [31:0] m_data, sts;

  always #5 clk = ~clk;

  axis_accumulator_mc #(
    .S_AXIS_TDATA_WIDTH(16), .M_AXIS_TDATA_WIDTH(32), .CNTR_WIDTH(16), .CHANNELS(4),
    .AXIS_TDATA_SIGNED("FALSE"), .CONTINUOUS("TRUE")
  ) u_a (
    .aclk(clk), .areset(rst[0]), .cfg_data(cfg), .sts_data(a_sts), .s_axis_tready(a_srdy),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .m_axis_tready(m_tready),
    .m_axis_tdata(a_data), .m_axis_tvalid(a_vld), .m_axis_tlast(a_last)
`ifdef AXIS_ACCUMULATOR_MC_SAT_EN
    , .sts_overflow(a_ovf)
`endif
  );

  axis_accumulator_mc #(
    .S_AXIS_TDATA_WIDTH(16), .M_AXIS_TDATA_WIDTH(32), .CNTR_WIDTH(16), .CHANNELS(2),
    .AXIS_TDATA_SIGNED("TRUE"), .CONTINUOUS("FALSE")
  ) u_b (
    .aclk(clk), .areset(rst[1]), .cfg_data(cfg), .sts_data(b_sts), .s_axis_tready(b_srdy),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .m_axis_tready(m_tready),
    .m_axis_tdata(b_data), .m_axis_tvalid(b_vld), .m_axis_tlast(b_last)
`ifdef AXIS_ACCUMULATOR_MC_SAT_EN
    , .sts_overflow(b_ovf)
`endif
  );

  axis_accumulator_mc #(
    .S_AXIS_TDATA_WIDTH(16), .M_AXIS_TDATA_WIDTH(16), .CNTR_WIDTH(16), .CHANNELS(1),
    .AXIS_TDATA_SIGNED("FALSE"), .CONTINUOUS("TRUE")
  ) u_c (
    .aclk(clk), .areset(rst[2]), .cfg_data(cfg), .sts_data(c_sts), .s_axis_tready(c_srdy),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .m_axis_tready(m_tready),
    .m_axis_tdata(c_data), .m_axis_tvalid(c_vld), .m_axis_tlast(c_last)
`ifdef AXIS_ACCUMULATOR_MC_SAT_EN
    , .sts_overflow(c_ovf)
`endif
  );

`ifndef AXIS_ACCUMULATOR_MC_SAT_EN
  assign a_ovf = 1'b0;
  assign b_ovf = 1'b0;
  assign c_ovf = 1'b0;
`endif

  always_comb begin
    case (sel)
      1: begin
        s_rdy = b_srdy; m_vld = b_vld; m_last = b_last; m_data = b_data; sts = b_sts;
      end
      2: begin
        s_rdy = c_srdy; m_vld = c_vld; m_last = c_last; m_data = {16'h0, c_data}; sts = c_sts;
      end
      default: begin
        s_rdy = a_srdy; m_vld = a_vld; m_last = a_last; m_data = a_data; sts = a_sts;
      end
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int k);
    rst[k] = 1'b1;
    tick();
    tick();
    check("rst_srdy", {31'b0, s_rdy}, 32'd0);
    check("rst_vld", {31'b0, m_vld}, 32'd0);
    check("rst_last", {31'b0, m_last}, 32'd0);
    check("rst_data", m_data, 32'd0);
    check("rst_sts", sts, 32'd0);
    rst[k] = 1'b0;
    tick();
    check("run_after_rst", {31'b0, s_rdy}, 32'd1);
  endtask

  // Offer one sample and hold it until accepted, bounded by a cycle budget.
  task automatic send(input logic [15:0] d);
    s_tdata  = d;
    s_tvalid = 1'b1;
    for (int t = 0; t < 300; t++) begin
      if (s_rdy) break;
      tick();
    end
    check("send_rdy", {31'b0, s_rdy}, 32'd1);
    if (s_rdy) tick();
    s_tvalid = 1'b0;
  endtask

  // Take one result beat and compare it with the expected data and tlast.
  task automatic recv(input string tag, input logic [31:0] exp_d, input logic exp_last);
    for (int t = 0; t < 300; t++) begin
      if (m_vld) break;
      tick();
    end
    check({tag, "_vld"}, {31'b0, m_vld}, 32'd1);
    check({tag, "_data"}, m_data, exp_d);
    check({tag, "_last"}, {31'b0, m_last}, {31'b0, exp_last});
    m_tready = 1'b1;
    tick();
    m_tready = 1'b0;
  endtask

  int rdy_cnt;

  initial begin
    // ---- u_a: basic 4-channel burst, cfg=2
    sel = 0;
    cfg = 16'd2;
    do_reset(0);
    send(16'd1); send(16'd2); send(16'd3); send(16'd4);
    send(16'd10); send(16'd20); send(16'd30); send(16'd40);
    check("a1_first_vld", {31'b0, m_vld}, 32'd1);
    check("a1_sts", sts, 32'd1);
    recv("a1_w0", 32'd11, 1'b0);
    recv("a1_w1", 32'd22, 1'b0);
    recv("a1_w2", 32'd33, 1'b0);
    recv("a1_w3", 32'd44, 1'b1);
    check("a1_idle", {31'b0, m_vld}, 32'd0);

    // ---- block A completes and stays undrained; block B fills around it
    send(16'd5); send(16'd6); send(16'd7); send(16'd8);
    send(16'd100); send(16'd200); send(16'd300); send(16'd400);
    check("a2_sts", sts, 32'd2);
    send(16'd1);
    cfg = 16'd5;  // takes effect from the next block only
    send(16'd1); send(16'd1); send(16'd1);
    send(16'd2); send(16'd2); send(16'd2);
    s_tdata  = 16'd3;
    s_tvalid = 1'b1;
    rdy_cnt  = 0;
    for (int i = 0; i < 5; i++) begin
      if (s_rdy) rdy_cnt++;
      tick();
    end
    check("stall_last_sample", rdy_cnt, 32'd0);
    recv("a2_w0", 32'd105, 1'b0);
    recv("a2_w1", 32'd206, 1'b0);
    recv("a2_w2", 32'd307, 1'b0);
    recv("a2_w3", 32'd408, 1'b1);
    check("rdy_after_drain", {31'b0, s_rdy}, 32'd1);
    send(16'd3);
    check("a3_first_vld", {31'b0, m_vld}, 32'd1);
    check("a3_sts", sts, 32'd3);
    recv("a3_w0", 32'd3, 1'b0);
    recv("a3_w1", 32'd3, 1'b0);
    recv("a3_w2", 32'd3, 1'b0);
    recv("a3_w3", 32'd4, 1'b1);

    // ---- block C uses the new cfg of 5 frames
    for (int f = 0; f < 2; f++)
      for (int c = 0; c < 4; c++) send(16'(c + 1));
    check("a4_not_done", {31'b0, m_vld}, 32'd0);
    for (int f = 2; f < 5; f++)
      for (int c = 0; c < 4; c++) send(16'(c + 1));
    check("a4_sts", sts, 32'd4);
    recv("a4_w0", 32'd5, 1'b0);
    recv("a4_w1", 32'd10, 1'b0);
    recv("a4_w2", 32'd15, 1'b0);
    recv("a4_w3", 32'd20, 1'b1);

    // ---- cfg=0 means one frame per block
    cfg = 16'd0;
    send(16'd7); send(16'd8); send(16'd9); send(16'd10);
    check("a5_sts", sts, 32'd5);
    recv("a5_w0", 32'd7, 1'b0);
    recv("a5_w1", 32'd8, 1'b0);
    recv("a5_w2", 32'd9, 1'b0);
    recv("a5_w3", 32'd10, 1'b1);
    rst[0] = 1'b1;

    // ---- u_b: signed, 2 channels, cfg=3, single-shot
    sel = 1;
    cfg = 16'd3;
    do_reset(1);
    for (int f = 0; f < 3; f++) begin
      send(16'hFFFF);
      send(16'd5);
    end
    check("b1_sts", sts, 32'd1);
    recv("b1_w0", 32'hFFFF_FFFD, 1'b0);
    recv("b1_w1", 32'd15, 1'b1);
    s_tdata  = 16'd1;
    s_tvalid = 1'b1;
    rdy_cnt  = 0;
    for (int i = 0; i < 100; i++) begin
      if (s_rdy) rdy_cnt++;
      tick();
    end
    s_tvalid = 1'b0;
    check("b1_stopped", rdy_cnt, 32'd0);
    check("b1_no_more_out", {31'b0, m_vld}, 32'd0);
    cfg = 16'd1;
    do_reset(1);
    send(16'd7);
    send(16'hFFFE);
    check("b2_sts", sts, 32'd1);
    check("b2_stopped", {31'b0, s_rdy}, 32'd0);
    recv("b2_w0", 32'd7, 1'b0);
    recv("b2_w1", 32'hFFFF_FFFE, 1'b1);
    rst[1] = 1'b1;

    // ---- u_c: 1 channel, 16-bit, 0xFFFF + 0x0002
    sel = 2;
    cfg = 16'd2;
    do_reset(2);
`ifdef AXIS_ACCUMULATOR_MC_SAT_EN
    check("c_ovf_rst", {31'b0, c_ovf}, 32'd0);
`endif
    send(16'hFFFF);
    send(16'h0002);
`ifdef AXIS_ACCUMULATOR_MC_SAT_EN
    recv("c1_sat", 32'h0000_FFFF, 1'b1);
    check("c_ovf_set", {31'b0, c_ovf}, 32'd1);
`else
    recv("c1_wrap", 32'h0000_0001, 1'b1);
`endif
    cfg = 16'd1;
    send(16'd5);
    check("c2_sts", sts, 32'd2);
    recv("c2_w0", 32'd5, 1'b1);
`ifdef AXIS_ACCUMULATOR_MC_SAT_EN
    check("c_ovf_sticky", {31'b0, c_ovf}, 32'd1);
`endif
    check("c2_idle", {31'b0, m_vld}, 32'd0);
    rst[2] = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
